// File: rtl/wb_regfile_pkg.sv
//------------------------------------------------------------------------------
// Module      : wb_regfile_pkg
// Description : Shared pipeline constants and dump FSM state encodings.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_regfile_pkg;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int NB_PC   = 32;
  localparam int N_REGS  = 32;

  localparam logic [NB_REG-1:0] LINK_REG = 5'd31;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DUMP = 1'b1
  } dump_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
//------------------------------------------------------------------------------
// Module      : regfile_dump_ctrl
// Description : Debug dump sequencer; walks register indices 0..N_REGS-1.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_dump_ctrl #(
  parameter int NB_DATA = wb_regfile_pkg::NB_DATA,
  parameter int NB_REG  = wb_regfile_pkg::NB_REG,
  parameter int N_REGS  = wb_regfile_pkg::N_REGS
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_dump_start,
  input  logic [NB_DATA-1:0] i_rd_data,
  output logic [NB_REG-1:0]  o_rd_addr,
  output logic               o_dump_busy,
  output logic               o_dump_valid,
  output logic [NB_REG-1:0]  o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_last
);

  import wb_regfile_pkg::*;

  localparam logic [NB_REG-1:0] c_LAST_IDX = NB_REG'(N_REGS - 1);

  dump_state_e        state_q, state_d;
  logic [NB_REG-1:0]  addr_q,  addr_d;
  logic               valid_q, valid_d;
  logic               last_q,  last_d;
  logic [NB_DATA-1:0] data_q,  data_d;

  // o_rd_addr is the index of the beat being loaded at the coming edge.
  always_comb begin
    state_d   = state_q;
    addr_d    = '0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    o_rd_addr = '0;
    case (state_q)
      IDLE: begin
        if (i_dump_start) begin
          state_d = DUMP;
          valid_d = 1'b1;
        end
      end
      DUMP: begin
        if (addr_q == c_LAST_IDX) begin
          state_d = IDLE;
        end else begin
          valid_d   = 1'b1;
          addr_d    = addr_q + 1'b1;
          o_rd_addr = addr_d;
          last_d    = (addr_d == c_LAST_IDX);
        end
      end
      default: state_d = IDLE;
    endcase
    data_d = valid_d ? i_rd_data : '0;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign o_dump_busy  = (state_q == DUMP);
  assign o_dump_valid = valid_q;
  assign o_dump_addr  = addr_q;
  assign o_dump_data  = data_q;
  assign o_dump_last  = last_q;

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
//------------------------------------------------------------------------------
// Module      : wb_regfile
// Description : Write-back stage register file with write-through bypass and debug dump.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_regfile #(
  parameter int NB_DATA = wb_regfile_pkg::NB_DATA,
  parameter int NB_REG  = wb_regfile_pkg::NB_REG,
  parameter int NB_PC   = wb_regfile_pkg::NB_PC,
  parameter int N_REGS  = wb_regfile_pkg::N_REGS
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_WB_reg_write,
  input  logic               i_WB_mem_to_reg,
  input  logic [NB_DATA-1:0] i_WB_mem_data,
  input  logic [NB_DATA-1:0] i_WB_alu_result,
  input  logic [NB_REG-1:0]  i_WB_selected_reg,
  input  logic               i_WB_r31_ctrl,
  input  logic [NB_PC-1:0]   i_WB_pc,
  input  logic [NB_REG-1:0]  i_ID_rs_addr,
  input  logic [NB_REG-1:0]  i_ID_rt_addr,
  output logic [NB_DATA-1:0] o_ID_rs_data,
  output logic [NB_DATA-1:0] o_ID_rt_data,
  output logic [NB_DATA-1:0] o_WB_write_data,
  input  logic               i_dump_start,
  output logic               o_dump_busy,
  output logic               o_dump_valid,
  output logic [NB_REG-1:0]  o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_last
);

  import wb_regfile_pkg::*;

  logic [NB_DATA-1:0] regs_q [N_REGS];
  logic [NB_DATA-1:0] w_wdata;
  logic [NB_REG-1:0]  w_waddr;
  logic               w_we;
  logic [NB_REG-1:0]  w_dump_rd_addr;
  logic [NB_DATA-1:0] w_dump_rd_data;

  assign w_wdata = i_WB_r31_ctrl   ? NB_DATA'(i_WB_pc) :
                   i_WB_mem_to_reg ? i_WB_mem_data     : i_WB_alu_result;
  assign w_waddr = i_WB_r31_ctrl ? NB_REG'(LINK_REG) : i_WB_selected_reg;
  // A write in a reset cycle is dropped, so it must not be bypassed either.
  assign w_we    = i_reset && i_WB_reg_write && (w_waddr != '0);

  assign o_WB_write_data = w_wdata;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else if (w_we) begin
      regs_q[w_waddr] <= w_wdata;
    end
  end

  assign o_ID_rs_data   = (i_ID_rs_addr == '0) ? '0 :
                          (w_we && i_ID_rs_addr == w_waddr) ? w_wdata : regs_q[i_ID_rs_addr];
  assign o_ID_rt_data   = (i_ID_rt_addr == '0) ? '0 :
                          (w_we && i_ID_rt_addr == w_waddr) ? w_wdata : regs_q[i_ID_rt_addr];
  assign w_dump_rd_data = (w_dump_rd_addr == '0) ? '0 :
                          (w_we && w_dump_rd_addr == w_waddr) ? w_wdata : regs_q[w_dump_rd_addr];

  regfile_dump_ctrl #(
    .NB_DATA (NB_DATA),
    .NB_REG  (NB_REG),
    .N_REGS  (N_REGS)
  ) u_dump_ctrl (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_dump_start (i_dump_start),
    .i_rd_data    (w_dump_rd_data),
    .o_rd_addr    (w_dump_rd_addr),
    .o_dump_busy  (o_dump_busy),
    .o_dump_valid (o_dump_valid),
    .o_dump_addr  (o_dump_addr),
    .o_dump_data  (o_dump_data),
    .o_dump_last  (o_dump_last)
  );

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameters SHALL be: NB_DATA 32, data width; NB_REG 5, register address width; NB_PC 32, PC width; N_REGS 32, register count.
REQ-002 i_clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_reset  in  1  reset, synchronous, active-low.
REQ-004 i_WB_reg_write  in  1  write enable from the MEM/WB pipeline register.
REQ-005 i_WB_mem_to_reg  in  1  1 selects the memory data source, 0 selects the ALU result.
REQ-006 i_WB_mem_data  in  NB_DATA  load data.
REQ-007 i_WB_alu_result  in  NB_DATA  ALU result.
REQ-008 i_WB_selected_reg  in  NB_REG  destination register.
REQ-009 i_WB_r31_ctrl  in  1  link write (jal/jalr).
REQ-010 i_WB_pc  in  NB_PC  return address for link write.
REQ-011 i_ID_rs_addr, i_ID_rt_addr  in  NB_REG each  decode-stage read addresses.
REQ-012 o_ID_rs_data, o_ID_rt_data  out  NB_DATA each  read data.
REQ-013 o_WB_write_data  out  NB_DATA  selected write-back value, used for forwarding.
REQ-014 i_dump_start  in  1  debug dump request, one-cycle pulse.
REQ-015 o_dump_busy  out  1  dump in progress.
REQ-016 o_dump_valid  out  1  o_dump_addr/o_dump_data valid this cycle.
REQ-017 o_dump_addr  out  NB_REG  register index being dumped.
REQ-018 o_dump_data  out  NB_DATA  register contents being dumped.
REQ-019 o_dump_last  out  1  asserted with the final (index 31) beat.

Function
REQ-020 Write data SHALL be i_WB_pc when r31_ctrl=1, else mem_data when mem_to_reg=1, else alu_result; o_WB_write_data SHALL be this value, combinationally.
REQ-021 Write address SHALL be 31 when r31_ctrl=1, else i_WB_selected_reg.
REQ-022 A write SHALL occur at the clock edge when reg_write=1 and the write address is not 0.
REQ-023 Register 0 SHALL always read 0; writes to it SHALL be discarded.
REQ-024 Reads SHALL be combinational; when a read address equals a write address with a write pending this cycle (and the address is not 0), the read SHALL return the write data (write-through bypass).
REQ-025 Dump FSM states SHALL be IDLE and DUMP. IDLE->DUMP on i_dump_start. In DUMP, one register is emitted per cycle for indices 0..31 in order. After index 31 the FSM SHALL return to IDLE.
REQ-026 Dump outputs SHALL be registered: first valid beat (index 0) one cycle after the start pulse; 32 consecutive valid beats; valid and busy then deassert the following cycle.
REQ-027 o_dump_busy SHALL be high from the cycle after start through the last beat.
REQ-028 i_dump_start while busy SHALL be ignored, with no restart.
REQ-029 o_dump_data SHALL use the bypassed value, so a same-cycle WB write to the dumped index is reflected.
REQ-030 WB writes and ID reads SHALL proceed unaffected during a dump.

Reset
REQ-031 While i_reset=0 at a clock edge, all 32 registers SHALL clear to 0, the FSM SHALL go to IDLE, and o_dump_valid, o_dump_busy, o_dump_last, o_dump_addr and o_dump_data SHALL be 0.
REQ-032 Reset during a dump SHALL abort it; no further beats; a new start is needed.
REQ-033 A write requested in a reset cycle SHALL be discarded.

Structure
REQ-034 NB_DATA, NB_REG, NB_PC, N_REGS, the link register index 31 and the dump FSM state encodings SHALL reside in the shared pipeline package.
REQ-035 The dump sequencer SHALL be the one sub-module, regfile_dump_ctrl (FSM + index counter); the array, the write mux and the bypass SHALL stay in wb_regfile.

Verification
REQ-036 Post-reset: read rs=5, rt=31 -> both 0; o_dump_valid=0.
REQ-037 Write-back mux: reg_write=1, mem_to_reg=1, mem_data=0xDEADBEEF, sel=8 -> next cycle rs=8 reads 0xDEADBEEF. Then mem_to_reg=0, alu=0x12, sel=8 -> reads 0x12.
REQ-038 Link write: r31_ctrl=1, pc=0x00000040, sel=4 -> r31=0x40, r4 unchanged.
REQ-039 r0 write and bypass: write 0xFFFFFFFF to r0 -> reads 0. Write 0xA5 to r9 with rs=9 in the same cycle -> o_ID_rs_data=0xA5 before the edge.
REQ-040 Dump: preload rK=K*4 and pulse start -> 32 valid beats, addr 0..31, data K*4, last only on beat 31. A second start at beat 10 is ignored.
REQ-041 Reset abort: reset asserted at dump beat 12 -> valid=0 next cycle, all registers read 0, no further beats.
